qupls_alu_dispatch: RTL

Per-unit dispatch sequencer between the issue scheduler and one ALU. It accepts a registered issue index/valid pair, captures the operands and opcode from the ROB entry, and sequences the operation through its latency. It then holds the result until the writeback arbiter accepts it, and drives the `idle` signal that the scheduler uses to gate further issue. One instance is placed per ALU (alu0, alu1).

---
 rtl/qupls_alu_dispatch_pkg.sv | 46 ++++
 rtl/qupls_alu_dispatch_if.sv | 33 +++
 rtl/qupls_lat_counter.sv | 28 ++
 rtl/qupls_alu_dispatch.sv | 120 ++++++++++++
 4 files changed

// File: rtl/qupls_alu_dispatch_pkg.sv
// Shared Qupls types for the ALU dispatch sequencer: ROB entry layout,
// index/value/instruction types, dispatch FSM states and default latencies.
package qupls_alu_dispatch_pkg;

  localparam int unsigned ROB_ENTRIES = 16;
  localparam int unsigned ROB_NDX_W   = $clog2(ROB_ENTRIES);
  localparam int unsigned VALUE_W     = 64;
  localparam int unsigned INSTR_W     = 32;

  localparam int unsigned DEF_MUL_LAT = 3;
  localparam int unsigned DEF_DIV_LAT = 20;

  typedef logic [ROB_NDX_W-1:0] rob_ndx_t;
  typedef logic [VALUE_W-1:0]   value_t;
  typedef logic [INSTR_W-1:0]   instruction_t;

  typedef struct packed {
    logic mul;
    logic div;
  } decode_bus_t;

  typedef struct packed {
    logic         v;
    decode_bus_t  decbus;
    instruction_t op;
    value_t       argA;
    value_t       argB;
    value_t       argC;
  } rob_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } alu_disp_state_t;

  // Execution latency of an op; divide wins when both decode bits are set.
  function automatic int unsigned op_latency(input logic mul, input logic div,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    if (div)      return div_lat;
    else if (mul) return mul_lat;
    else          return 1;
  endfunction

endpackage

// File: rtl/qupls_alu_dispatch_if.sv
// Issue, ALU-operand and writeback signals of one ALU dispatch unit.
// slave: the dispatcher. master: scheduler / ALU datapath / writeback arbiter.
interface qupls_alu_dispatch_if;
  import qupls_alu_dispatch_pkg::*;

  rob_ndx_t     rndx;
  logic         rndxv;
  logic         idle;
  logic         ald;
  instruction_t op_instr;
  value_t       op_a;
  value_t       op_b;
  value_t       op_c;
  rob_ndx_t     op_rndx;
  value_t       res_i;
  logic         wb_req;
  logic         wb_ack;
  value_t       wb_res;
  rob_ndx_t     wb_rndx;
  logic [1:0]   wb_islot;

  modport slave (
    input  rndx, rndxv, res_i, wb_ack,
    output idle, ald, op_instr, op_a, op_b, op_c, op_rndx,
           wb_req, wb_res, wb_rndx, wb_islot
  );

  modport master (
    output rndx, rndxv, res_i, wb_ack,
    input  idle, ald, op_instr, op_a, op_b, op_c, op_rndx,
           wb_req, wb_res, wb_rndx, wb_islot
  );
endinterface

// File: rtl/qupls_lat_counter.sv
// Loadable down-counter with a zero flag, used to time multi-cycle ops.
// Ports: clk, rst (async high), clr (sync clear), load/load_val, dec,
// zero_c (combinational count==0).
module qupls_lat_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // clear beats load beats decrement; saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/qupls_alu_dispatch.sv
// Per-ALU dispatch sequencer: accepts an issued ROB index, captures the
// operands, times the op latency, then holds the result for writeback.
// Ports: clk, rst (async high), rob (ROB contents), flush, bus (issue,
// operand and writeback signals, see qupls_alu_dispatch_if).
module qupls_alu_dispatch
  import qupls_alu_dispatch_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT,
  parameter int unsigned UNIT_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  rob_entry_t            rob [ROB_ENTRIES],
  input  logic                  flush,
  qupls_alu_dispatch_if.slave   bus
);

  // Sized for the longer of the two latencies so either fits as lat-1.
  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  alu_disp_state_t state_q, state_d;
  logic            accept_c;
  logic            capture_c;
  logic            dec_c;
  logic            kill_c;
  logic            cnt_zero_c;
  logic [CNT_W-1:0] lat_m1_c;

  // An op whose ROB entry was invalidated is dead as well as a flushed one.
  assign kill_c = flush || ((state_q != IDLE) && !rob[bus.op_rndx].v);

  assign lat_m1_c = CNT_W'(op_latency(rob[bus.rndx].decbus.mul,
                                      rob[bus.rndx].decbus.div,
                                      MUL_LAT, DIV_LAT) - 32'd1);

  qupls_lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .clr      (kill_c),
    .load     (accept_c),
    .load_val (lat_m1_c),
    .dec      (dec_c),
    .zero_c   (cnt_zero_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    dec_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rndxv) begin
          accept_c = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_zero_c) begin
          capture_c = 1'b1;
          state_d   = WB;
        end else begin
          dec_c = 1'b1;
        end
      end
      WB: begin
        if (bus.wb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill_c) begin
      state_d   = IDLE;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      dec_c     = 1'b0;
    end
  end

  // Operand capture and result hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ald      <= 1'b0;
      bus.op_instr <= '0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
      bus.op_c     <= '0;
      bus.op_rndx  <= '0;
      bus.wb_res   <= '0;
      bus.wb_rndx  <= '0;
    end else begin
      bus.ald <= accept_c;
      if (accept_c) begin
        bus.op_instr <= rob[bus.rndx].op;
        bus.op_a     <= rob[bus.rndx].argA;
        bus.op_b     <= rob[bus.rndx].argB;
        bus.op_c     <= rob[bus.rndx].argC;
        bus.op_rndx  <= bus.rndx;
      end
      if (capture_c) begin
        bus.wb_res  <= bus.res_i;
        bus.wb_rndx <= bus.op_rndx;
      end
    end
  end

  // idle drops in the accept cycle; wb_req is masked the cycle a kill arrives.
  assign bus.idle     = (state_q == IDLE) && !bus.rndxv;
  assign bus.wb_req   = (state_q == WB) && !kill_c;
  assign bus.wb_islot = 2'(UNIT_ID);

endmodule
